// File: rtl/core_bus_pkg.sv
// ---------------------------------------------------------------------------
// core_bus_pkg
//   Shared definitions for the riscv_core memory-side bus: default data and
//   address widths, a helper that derives the byte-enable width from a data
//   width, and the identifiers of the two core memory ports.
// ---------------------------------------------------------------------------
package core_bus_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

  // Identifies which core port currently owns the SRAM.
  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_id_e;

  // Number of byte lanes carried by a data word of the given width.
  function automatic int beWidth(input int dataW);
    return dataW / 8;
  endfunction

endpackage

// File: rtl/core_mem_arbiter.sv
// ---------------------------------------------------------------------------
// core_mem_arbiter
//   Shares one single-port synchronous SRAM between the core's instruction
//   fetch (IF) port and its load/store (LS) port. LS has priority, but after
//   MAX_LS_RUN consecutive LS grants taken while IF was waiting, IF is given
//   the next slot. Read data returns one cycle after the grant and is steered
//   to the requesting port by its rvalid strobe.
//
// Ports
//   sys_clk, sys_rst_n      clock, asynchronous active-low reset
//   if_req/if_addr          IF read request and byte address
//   if_gnt                  IF request accepted this cycle
//   if_rvalid/if_rdata      IF read response
//   ls_req/ls_we/ls_addr    LS request, write flag and byte address
//   ls_wdata/ls_be          LS write data and byte enables
//   ls_gnt                  LS request accepted this cycle
//   ls_rvalid/ls_rdata      LS read response
//   mem_ce/mem_we           SRAM chip enable and write enable
//   mem_addr                SRAM word address
//   mem_wdata/mem_be        SRAM write data and byte enables
//   mem_rdata               SRAM read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module core_mem_arbiter
  import core_bus_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int MEM_AW     = 12,
  parameter int MAX_LS_RUN = 4
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        if_req,
  input  logic [ADDR_W-1:0]           if_addr,
  output logic                        if_gnt,
  output logic                        if_rvalid,
  output logic [DATA_W-1:0]           if_rdata,
  input  logic                        ls_req,
  input  logic                        ls_we,
  input  logic [ADDR_W-1:0]           ls_addr,
  input  logic [DATA_W-1:0]           ls_wdata,
  input  logic [beWidth(DATA_W)-1:0]  ls_be,
  output logic                        ls_gnt,
  output logic                        ls_rvalid,
  output logic [DATA_W-1:0]           ls_rdata,
  output logic                        mem_ce,
  output logic                        mem_we,
  output logic [MEM_AW-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [beWidth(DATA_W)-1:0]  mem_be,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam logic [3:0] MaxRun = 4'(MAX_LS_RUN);

  logic [3:0]  run_cnt_q, run_cnt_d;
  logic        if_rd_q, if_rd_d;
  logic        ls_rd_q, ls_rd_d;
  logic        ifGnt, lsGnt;
  port_id_e    owner;
  logic [ADDR_W-1:0] selAddr;

  // Byte offset and bits above the SRAM window are intentionally dropped.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{if_addr[ADDR_W-1:MEM_AW+2], if_addr[1:0],
                            ls_addr[ADDR_W-1:MEM_AW+2], ls_addr[1:0]};

  // Same-cycle arbitration. Reset masks both grants so nothing reaches the
  // SRAM while the core is held in reset.
  always_comb begin
    lsGnt = sys_rst_n & ls_req & (~if_req | (run_cnt_q < MaxRun));
    ifGnt = sys_rst_n & if_req & ~lsGnt;
    owner = lsGnt ? PORT_LS : PORT_IF;
  end

  assign if_gnt = ifGnt;
  assign ls_gnt = lsGnt;

  // SRAM drive from the granted port; IF always fetches whole words.
  always_comb begin
    selAddr   = (owner == PORT_LS) ? ls_addr : if_addr;
    mem_ce    = lsGnt | ifGnt;
    mem_we    = lsGnt & ls_we;
    mem_addr  = selAddr[MEM_AW+1:2];
    mem_be    = (owner == PORT_LS) ? ls_be : '1;
    mem_wdata = ls_wdata;
  end

  // Run counter counts LS grants taken while IF is waiting; once it reaches
  // the limit IF wins the next contended cycle and the count restarts.
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (lsGnt && if_req) begin
      run_cnt_d = (run_cnt_q >= MaxRun) ? MaxRun : run_cnt_q + 4'd1;
    end else if (ifGnt || !if_req) begin
      run_cnt_d = '0;
    end
    if_rd_d = ifGnt;
    ls_rd_d = lsGnt & ~ls_we;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run_cnt_q <= '0;
      if_rd_q   <= 1'b0;
      ls_rd_q   <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      if_rd_q   <= if_rd_d;
      ls_rd_q   <= ls_rd_d;
    end
  end

  // Read data is shared; only the rvalid of the owning port qualifies it.
  assign if_rvalid = if_rd_q;
  assign ls_rvalid = ls_rd_q;
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_core_mem_arbiter
//   Directed bench for core_mem_arbiter with a behavioural single-port SRAM.
// ---------------------------------------------------------------------------
module tb_core_mem_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [3:0]  ls_be = '0;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_ce, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  int vecCount = 0;
  int missCount = 0;

  typedef struct {
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        lsReq;
    logic        lsWe;
    logic [31:0] lsAddr;
    logic [31:0] lsWdata;
    logic [3:0]  lsBe;
    logic        expIfGnt;
    logic        expLsGnt;
    logic        expCe;
    logic        expWe;
    logic        chkAddr;
    logic [11:0] expAddr;
    logic [3:0]  expBe;
    logic        expIfRv;
    logic        expLsRv;
    logic [31:0] expRdata;
  } vec_t;

  core_mem_arbiter #(
    .DATA_W(32), .ADDR_W(32), .MEM_AW(12), .MAX_LS_RUN(4)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_be(ls_be), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioural single-port SRAM: byte-masked write, one-cycle read.
  logic [31:0] sram [4096];
  always @(posedge sys_clk) begin
    if (mem_ce) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  function automatic vec_t mk(
    input logic ifReq, input logic [31:0] ifAddr,
    input logic lsReq, input logic lsWe, input logic [31:0] lsAddr,
    input logic [31:0] lsWdata, input logic [3:0] lsBe,
    input logic eIfG, input logic eLsG, input logic eCe, input logic eWe,
    input logic chk, input logic [11:0] eAddr, input logic [3:0] eBe,
    input logic eIfRv, input logic eLsRv, input logic [31:0] eRdata);
    vec_t v;
    v.ifReq = ifReq; v.ifAddr = ifAddr; v.lsReq = lsReq; v.lsWe = lsWe;
    v.lsAddr = lsAddr; v.lsWdata = lsWdata; v.lsBe = lsBe;
    v.expIfGnt = eIfG; v.expLsGnt = eLsG; v.expCe = eCe; v.expWe = eWe;
    v.chkAddr = chk; v.expAddr = eAddr; v.expBe = eBe;
    v.expIfRv = eIfRv; v.expLsRv = eLsRv; v.expRdata = eRdata;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    if_req   = v.ifReq;
    if_addr  = v.ifAddr;
    ls_req   = v.lsReq;
    ls_we    = v.lsWe;
    ls_addr  = v.lsAddr;
    ls_wdata = v.lsWdata;
    ls_be    = v.lsBe;
  endtask

  task automatic checkOutput(input vec_t v, input string name);
    logic ok;
    ok = 1'b1;
    vecCount++;
    if (if_gnt !== v.expIfGnt || ls_gnt !== v.expLsGnt) ok = 1'b0;
    if (mem_ce !== v.expCe || mem_we !== v.expWe) ok = 1'b0;
    if (v.chkAddr && (mem_addr !== v.expAddr || mem_be !== v.expBe)) ok = 1'b0;
    if (v.expWe && mem_wdata !== v.lsWdata) ok = 1'b0;
    if (if_rvalid !== v.expIfRv || ls_rvalid !== v.expLsRv) ok = 1'b0;
    if (v.expIfRv && if_rdata !== v.expRdata) ok = 1'b0;
    if (v.expLsRv && ls_rdata !== v.expRdata) ok = 1'b0;
    if (!ok) begin
      missCount++;
      $display("[TB] FAIL %s: got gnt if/ls=%b/%b ce=%b we=%b addr=%h be=%h wdata=%h rv if/ls=%b/%b rdata if/ls=%h/%h, want gnt %b/%b ce=%b we=%b addr=%h be=%h rv %b/%b rdata=%h",
               name, if_gnt, ls_gnt, mem_ce, mem_we, mem_addr, mem_be, mem_wdata,
               if_rvalid, ls_rvalid, if_rdata, ls_rdata,
               v.expIfGnt, v.expLsGnt, v.expCe, v.expWe, v.expAddr, v.expBe,
               v.expIfRv, v.expLsRv, v.expRdata);
    end
  endtask

  task automatic checkBits(input string name, input logic [7:0] actual,
                           input logic [7:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %b, want %b", name, actual, expected);
    end
  endtask

  vec_t vecs[$];

  initial begin
    sram[0] = 32'h11;
    sram[1] = 32'h22;
    sram[2] = 32'h33;

    //           ifR ifAddr       lsR we lsAddr       lsWdata       be     iG lG ce we chk addr   be     iRv lRv rdata
    vecs.push_back(mk(1, 32'h0,    0, 0, 32'h0,    32'h0,        4'h0, 1, 0, 1, 0, 1, 12'd0, 4'hF, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h4,    0, 0, 32'h0,    32'h0,        4'h0, 1, 0, 1, 0, 1, 12'd1, 4'hF, 1, 0, 32'h11));
    vecs.push_back(mk(1, 32'h8,    0, 0, 32'h0,    32'h0,        4'h0, 1, 0, 1, 0, 1, 12'd2, 4'hF, 1, 0, 32'h22));
    vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 0, 0, 0, 12'd0, 4'h0, 1, 0, 32'h33));
    vecs.push_back(mk(0, 32'h0,    1, 1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 1, 1, 1, 1, 12'd4, 4'hF, 0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,    1, 0, 32'h10,   32'h0,        4'hF, 0, 1, 1, 0, 1, 12'd4, 4'hF, 0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,    1, 1, 32'h10,   32'h0000AB00, 4'h2, 0, 1, 1, 1, 1, 12'd4, 4'h2, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 32'h0,    1, 0, 32'h10,   32'h0,        4'hF, 0, 1, 1, 0, 1, 12'd4, 4'hF, 0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 0, 0, 0, 12'd0, 4'h0, 0, 1, 32'hDEADABEF));
    vecs.push_back(mk(0, 32'h0,    1, 0, 32'h4000, 32'h0,        4'hF, 0, 1, 1, 0, 1, 12'd0, 4'hF, 0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,    1, 1, 32'h20,   32'hCAFEF00D, 4'hF, 0, 1, 1, 1, 1, 12'd8, 4'hF, 0, 1, 32'h11));
    vecs.push_back(mk(1, 32'h20,   0, 0, 32'h0,    32'h0,        4'h0, 1, 0, 1, 0, 1, 12'd8, 4'hF, 0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 0, 0, 0, 12'd0, 4'h0, 1, 0, 32'hCAFEF00D));
    vecs.push_back(mk(1, 32'h4,    1, 0, 32'h8,    32'h0,        4'hF, 0, 1, 1, 0, 1, 12'd2, 4'hF, 0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,    1, 1, 32'h8,    32'h000000AA, 4'h1, 0, 1, 1, 1, 1, 12'd2, 4'h1, 0, 1, 32'h33));
    vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 0, 0, 0, 12'd0, 4'h0, 0, 0, 32'h0));

    // Reset state: requests asserted while reset is held must not be granted.
    @(negedge sys_clk);
    if_req = 1'b1;
    ls_req = 1'b1;
    #1;
    checkBits("reset_hold", {3'b0, if_gnt, ls_gnt, mem_ce, if_rvalid, ls_rvalid}, 8'b0);
    @(negedge sys_clk);
    if_req = 1'b0;
    ls_req = 1'b0;
    sys_rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge sys_clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset arriving while an IF read is being granted.
    @(negedge sys_clk);
    if_req = 1'b1;
    if_addr = 32'h0;
    ls_req = 1'b0;
    ls_we = 1'b0;
    #1;
    checkBits("rstB_gnt_before", {7'b0, if_gnt}, 8'b1);
    #3;
    sys_rst_n = 1'b0;
    #1;
    checkBits("rstB_gnt_in_reset", {5'b0, if_gnt, ls_gnt, mem_ce}, 8'b0);
    @(posedge sys_clk);
    #1;
    checkBits("rstB_no_rvalid", {6'b0, if_rvalid, ls_rvalid}, 8'b0);
    @(negedge sys_clk);
    if_req = 1'b0;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    #1;
    checkBits("rstB_after_release", {6'b0, if_rvalid, ls_rvalid}, 8'b0);

    // Build up the run counter, then reset during a contended LS read.
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      if_req = 1'b1;
      if_addr = 32'h4;
      ls_req = 1'b1;
      ls_we = 1'b0;
      ls_addr = 32'h8;
      ls_be = 4'hF;
      #1;
      checkBits($sformatf("pump%0d", i), {6'b0, if_gnt, ls_gnt}, 8'b01);
    end
    @(negedge sys_clk);
    #1;
    checkBits("rstA_gnt_before", {6'b0, if_gnt, ls_gnt}, 8'b01);
    #3;
    sys_rst_n = 1'b0;
    #1;
    checkBits("rstA_gnt_in_reset", {5'b0, if_gnt, ls_gnt, mem_ce}, 8'b0);
    @(posedge sys_clk);
    #1;
    checkBits("rstA_no_rvalid", {6'b0, if_rvalid, ls_rvalid}, 8'b0);

    // Starvation guard from a freshly reset run counter, both requests held.
    begin
      logic prevIf, prevLs, wantIf;
      prevIf = 1'b0;
      prevLs = 1'b0;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
        if (i > 0) @(negedge sys_clk);
        #1;
        wantIf = (i == 4) || (i == 9);
        checkBits($sformatf("starve%0d", i),
                  {4'b0, if_gnt, ls_gnt, if_rvalid, ls_rvalid},
                  {4'b0, wantIf, ~wantIf, prevIf, prevLs});
        prevIf = wantIf;
        prevLs = ~wantIf;
      end
    end

    @(negedge sys_clk);
    if_req = 1'b0;
    ls_req = 1'b0;
    @(negedge sys_clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
